// File: rtl/muldiv_alu_if.sv
// Request/response bundle for muldiv_alu.
// Master issues operations and consumes results; slave is the ALU.
interface muldiv_alu_if #(
    parameter int LEN = 32
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [LEN-1:0] opa;
    logic [LEN-1:0] opb;
    logic           out_valid;
    logic           out_ready;
    logic [LEN-1:0] result;
    logic [1:0]     sign_bits;

    modport master (
        output flush, in_valid, op, opa, opb, out_ready,
        input  in_ready, out_valid, result, sign_bits
    );

    modport slave (
        input  flush, in_valid, op, opa, opb, out_ready,
        output in_ready, out_valid, result, sign_bits
    );
endinterface

// File: rtl/muldiv_alu.sv
// Integer ALU with iterative radix-2 multiply and divide.
// Single-cycle ops finish next cycle; MUL/DIV family takes LEN+1 cycles.
module muldiv_alu #(
    parameter int LEN = 32,
    parameter int SHW = $clog2(LEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_alu_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;
    logic [LEN-1:0]   hi_q, lo_q, b_q, res_q;
    logic [1:0]       sb_q;
    logic             negp_q, negr_q;

    logic             accept;
    logic             is_long;
    logic             sgn_op;
    logic             sa, sb;
    logic [LEN-1:0]   ma, mb;
    logic [SHW-1:0]   shamt;
    logic [LEN-1:0]   alu_d;
    logic [LEN:0]     sum, rem, diff;
    logic             ge;
    logic [LEN-1:0]   hi_d, lo_d;
    logic [2*LEN-1:0] prod, prod_s;
    logic [LEN-1:0]   quo, rmd, fin_d;

    function automatic logic [1:0] cls(input logic [LEN-1:0] v);
        if (v == '0)        return 2'b00;
        else if (v[LEN-1])  return 2'b10;
        else                return 2'b01;
    endfunction

    assign bus.in_ready  = rst_n && !bus.flush &&
                           (state_q == IDLE ||
                            (state_q == DONE && bus.out_ready));
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.sign_bits = sb_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign is_long = bus.op[3] & (bus.op[2] | bus.op[1]);
    // DIVU/REMU are the only unsigned iterative ops
    assign sgn_op  = bus.op[2] ? !bus.op[0] : 1'b1;
    assign sa      = sgn_op && bus.opa[LEN-1];
    assign sb      = sgn_op && bus.opb[LEN-1];
    assign ma      = sa ? -bus.opa : bus.opa;
    assign mb      = sb ? -bus.opb : bus.opb;
    assign shamt   = bus.opb[SHW-1:0];

    // Single-cycle ALU result
    always_comb begin
        alu_d = '0;
        case (bus.op)
            4'd0:    alu_d = bus.opa + bus.opb;
            4'd1:    alu_d = bus.opa - bus.opb;
            4'd2:    alu_d = {{(LEN-1){1'b0}},
                              $signed(bus.opa) < $signed(bus.opb)};
            4'd3:    alu_d = {{(LEN-1){1'b0}}, bus.opa < bus.opb};
            4'd4:    alu_d = bus.opa ^ bus.opb;
            4'd5:    alu_d = bus.opa | bus.opb;
            4'd6:    alu_d = bus.opa & bus.opb;
            4'd7:    alu_d = bus.opa << shamt;
            4'd8:    alu_d = bus.opa >> shamt;
            4'd9:    alu_d = LEN'($signed(bus.opa) >>> shamt);
            default: alu_d = '0;
        endcase
    end

    // One iteration step on magnitudes, plus sign fix-up of the final step
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem  = {hi_q, lo_q[LEN-1]};
        diff = rem - {1'b0, b_q};
        ge   = rem >= {1'b0, b_q};
        if (op_q[2]) begin
            hi_d = ge ? diff[LEN-1:0] : rem[LEN-1:0];
            lo_d = {lo_q[LEN-2:0], ge};
        end else begin
            hi_d = sum[LEN:1];
            lo_d = {sum[0], lo_q[LEN-1:1]};
        end
        prod   = {hi_d, lo_d};
        prod_s = negp_q ? -prod : prod;
        quo    = (b_q == '0) ? '1 : (negp_q ? -lo_d : lo_d);
        rmd    = negr_q ? -hi_d : hi_d;
        case (op_q[2:0])
            3'b010:  fin_d = prod_s[LEN-1:0];
            3'b011:  fin_d = prod_s[2*LEN-1:LEN];
            3'b100,
            3'b101:  fin_d = quo;
            default: fin_d = rmd;
        endcase
    end

    // Control FSM with operand capture and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            sb_q    <= 2'b00;
        end else if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_long) begin
                            op_q    <= bus.op;
                            hi_q    <= '0;
                            lo_q    <= ma;
                            b_q     <= mb;
                            negp_q  <= sa ^ sb;
                            negr_q  <= sa;
                            cnt_q   <= SHW'(LEN-1);
                            state_q <= BUSY;
                        end else begin
                            res_q   <= alu_d;
                            sb_q    <= cls(alu_d);
                            state_q <= DONE;
                        end
                    end else if (state_q == IDLE || bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == '0) begin
                        res_q   <= fin_d;
                        sb_q    <= cls(fin_d);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_alu.sv
// Scoreboard bench for muldiv_alu at LEN=32 and LEN=8.
// Expected results are queued at acceptance and compared on output.
module tb_muldiv_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_alu_if #(.LEN(32)) b32();
    muldiv_alu_if #(.LEN(8))  b8();

    muldiv_alu #(.LEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    muldiv_alu #(.LEN(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct {
        logic [63:0] res;
        logic [1:0]  sb;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;
    int   nchk = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] cls(input logic [63:0] v, input int w);
        if (v == 64'd0)   return 2'b00;
        else if (v[w-1])  return 2'b10;
        else              return 2'b01;
    endfunction

    function automatic logic [31:0] ref32(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sbv = longint'($signed(b));
        longint      p;
        logic [63:0] pu;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return {31'b0, ($signed(a) < $signed(b))};
            4'd3:  return {31'b0, (a < b)};
            4'd4:  return a ^ b;
            4'd5:  return a | b;
            4'd6:  return a & b;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return 32'($signed(a) >>> b[4:0]);
            4'd10: begin pu = 64'(a) * 64'(b); return pu[31:0]; end
            4'd11: begin p = sa * sbv; return p[63:32]; end
            4'd12: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sbv;
                return p[31:0];
            end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sbv;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Compare each delivered 32-bit result with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && b32.out_valid && b32.out_ready) begin
            check("qdepth32", 64'(q32.size() > 0), 64'd1);
            if (q32.size() > 0) begin
                m32 = q32.pop_front();
                check("res32", b32.result, m32.res);
                check("sb32", b32.sign_bits, m32.sb);
                if (m32.lat != 0) check("lat32", cyc - m32.t0, m32.lat);
            end
        end
    end

    // Same for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && b8.out_valid && b8.out_ready) begin
            check("qdepth8", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                m8 = q8.pop_front();
                check("res8", b8.result, m8.res);
                check("sb8", b8.sign_bits, m8.sb);
                if (m8.lat != 0) check("lat8", cyc - m8.t0, m8.lat);
            end
        end
    end

    task automatic issue32(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r,
                           input bit lchk);
        exp_t e;
        bit   ok = 1'b0;
        b32.in_valid = 1'b1;
        b32.op  = o;
        b32.opa = a;
        b32.opb = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (b32.in_ready) begin
                e.res = 64'(r);
                e.sb  = cls(64'(r), 32);
                e.t0  = cyc;
                e.lat = lchk ? ((o >= 4'd10) ? 33 : 1) : 0;
                q32.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("accept32", 64'(ok), 64'd1);
        b32.in_valid = 1'b0;
        b32.op  = 4'($urandom);
        b32.opa = $urandom;
        b32.opb = $urandom;
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] r);
        exp_t e;
        bit   ok = 1'b0;
        b8.in_valid = 1'b1;
        b8.op  = o;
        b8.opa = a;
        b8.opb = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (b8.in_ready) begin
                e.res = 64'(r);
                e.sb  = cls(64'(r), 8);
                e.t0  = cyc;
                e.lat = (o >= 4'd10) ? 9 : 1;
                q8.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("accept8", 64'(ok), 64'd1);
        b8.in_valid = 1'b0;
        b8.opa = 8'($urandom);
        b8.opb = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++)
            @(posedge clk);
        #1;
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        int          nov;
        logic [3:0]  o;
        logic [31:0] a, b;

        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.op = '0;
        b32.opa = '0; b32.opb = '0; b32.out_ready = 1'b1;
        b8.flush = 1'b0; b8.in_valid = 1'b0; b8.op = '0;
        b8.opa = '0; b8.opb = '0; b8.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ov", b32.out_valid, 0);
        check("rst_res", b32.result, 0);
        check("rst_sb", b32.sign_bits, 0);
        check("rst_rdy", b32.in_ready, 0);
        check("rst_ov8", b8.out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue32(4'd0,  32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        issue32(4'd2,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        issue32(4'd3,  32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        issue32(4'd1,  32'd0, 32'd1, 32'hFFFF_FFFF, 1);
        issue32(4'd7,  32'd1, 32'h21, 32'd2, 1);
        issue32(4'd9,  32'h8000_0000, 32'd4, 32'hF800_0000, 1);
        issue32(4'd8,  32'h8000_0000, 32'd4, 32'h0800_0000, 1);
        issue32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1);
        issue32(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
        issue32(4'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        issue32(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        issue32(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        issue32(4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        issue32(4'd15, 32'd7, 32'd0, 32'd7, 1);
        issue32(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue32(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        issue32(4'd12, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        issue32(4'd14, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        drain();

        // Result must hold under back-pressure
        b32.out_ready = 1'b0;
        issue32(4'd0, 32'd10, 32'd20, 32'd30, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ov", b32.out_valid, 1);
            check("hold_res", b32.result, 30);
            check("hold_sb", b32.sign_bits, 2'b01);
            check("hold_rdy", b32.in_ready, 0);
            @(posedge clk);
            #1;
        end
        b32.out_ready = 1'b1;
        issue32(4'd0, 32'd5, 32'd6, 32'd11, 1);
        drain();

        // Flush a DIV in cycle T+10
        b32.in_valid = 1'b1; b32.op = 4'd12;
        b32.opa = 32'd1000; b32.opb = 32'd3;
        @(negedge clk);
        check("fl_acc_rdy", b32.in_ready, 1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 b32.flush = 1'b1;
        @(negedge clk);
        check("fl_rdy_low", b32.in_ready, 0);
        @(posedge clk);
        #1 b32.flush = 1'b0;
        @(negedge clk);
        check("fl_rdy", b32.in_ready, 1);
        check("fl_ov", b32.out_valid, 0);
        nov = 0;
        repeat (40) begin
            @(negedge clk);
            if (b32.out_valid) nov++;
        end
        check("fl_nov", 64'(nov), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a MUL
        b32.in_valid = 1'b1; b32.op = 4'd10;
        b32.opa = 32'd3; b32.opb = 32'd5;
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mr_rdy", b32.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mr_ov", b32.out_valid, 0);
        check("mr_res", b32.result, 0);
        check("mr_sb", b32.sign_bits, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nov = 0;
        repeat (40) begin
            @(negedge clk);
            if (b32.out_valid) nov++;
        end
        check("mr_nov", 64'(nov), 0);
        @(posedge clk);
        #1;
        issue32(4'd0, 32'd2, 32'd3, 32'd5, 1);
        drain();

        // 8-bit instance
        issue8(4'd9,  8'h80, 8'h0F, 8'hFF);
        issue8(4'd13, 8'd200, 8'd7, 8'd28);
        issue8(4'd12, 8'h80, 8'hFF, 8'h80);
        issue8(4'd11, 8'hF0, 8'h10, 8'hFF);
        drain();

        // Random traffic against the reference model
        for (int i = 0; i < 50; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 7) == 0)      b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            else                                b = $urandom;
            issue32(o, a, b, ref32(o, a, b), 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 Parameter LEN, default 32, datapath width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(LEN), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 flush  input  1  synchronous abort of any in-flight or held operation.
REQ-006 in_valid  input  1  operands and opcode valid this cycle.
REQ-007 in_ready  output  1  block can accept an operation this cycle.
REQ-008 op  input  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULH, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-009 opa, opb  input  LEN each  operands (opb may carry rs2 or imm; selection is external).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  LEN  registered result.
REQ-013 sign_bits  output  2  class of result as signed value: 2'b01 POS, 2'b00 ZERO, 2'b10 NEG.

Function
REQ-014 Acceptance SHALL occur in any cycle where in_valid && in_ready && !flush.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready is 1 (back-to-back issue); 0 in BUSY and on flush.
REQ-016 State machine SHALL have states IDLE, BUSY, DONE.
REQ-017 IDLE: acceptance of ops 0-9 -> DONE with result computed; acceptance of ops 10-15 -> BUSY with counter loaded to LEN-1.
REQ-018 BUSY: one radix-2 step per cycle (shift-add for MUL/MULH, restoring for DIV/REM); counter decrements; at counter 0 -> DONE.
REQ-019 DONE: out_valid=1; result and sign_bits SHALL stay stable until out_ready=1; on out_ready with new acceptance -> per REQ-017, otherwise -> IDLE.
REQ-020 Latency: ops 0-9 out_valid in cycle T+1 after acceptance in T; ops 10-15 out_valid in cycle T+LEN+1, independent of operand values.
REQ-021 ADD/SUB/XOR/OR/AND SHALL wrap modulo 2^LEN; SLT signed, SLTU unsigned, result 0 or 1.
REQ-022 Shifts SHALL use opb[SHW-1:0] only; SRA sign-fills.
REQ-023 MUL SHALL return low LEN bits of product; MULH high LEN bits of signed x signed product.
REQ-024 DIV/REM signed with quotient truncated toward zero, remainder sign of dividend; DIVU/REMU unsigned.
REQ-025 Divide by zero: quotient all ones, remainder = opa; no error flag; full latency still applies.
REQ-026 Signed overflow (opa = most negative, opb = -1): DIV returns opa, REM returns 0.
REQ-027 sign_bits SHALL be registered together with result and derived from result interpreted as signed.
REQ-028 flush SHALL force IDLE next cycle, clear out_valid, discard partial state; flush has priority over acceptance and out_ready in the same cycle.
REQ-029 Operands SHALL be captured at acceptance; changes to opa/opb/op afterwards SHALL not affect the result.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, out_valid=0, result=0, sign_bits=2'b00, counter=0; in_ready=0 while rst_n=0.
REQ-031 Reset asserted during BUSY or DONE SHALL abort the operation with no output; first acceptance possible in cycle after rst_n returns to 1.
REQ-032 Reset SHALL take priority over flush.

Verification
REQ-033 LEN=32, ADD 0xFFFFFFFF + 1, out_ready=1 -> out_valid at T+1, result 0, sign_bits 00; SLT 0xFFFFFFFF,1 -> 1; SLTU -> 0.
REQ-034 MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001 at T+33; MULH same operands -> 0x00000000; MULH 0x80000000 * 0x80000000 -> 0x40000000.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, sign_bits 10; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-036 Result held with out_ready=0 for 5 cycles -> result, sign_bits, out_valid constant, in_ready=0; then out_ready=1 with new ADD in same cycle -> new result next cycle.
REQ-037 flush at cycle T+10 of a DIV -> out_valid never asserts for it, in_ready=1 at T+11; rst_n=0 mid-MUL -> outputs at reset values, no stale result after release.
REQ-038 LEN=8 instance: SRA 0x80 by opb=0x0F (uses low 3 bits, 7) -> 0xFF; DIVU 200/7 -> 28 at T+9.
